ship_board: RTL and testbench
=============================

// Module: ship_board
// PURPOSE
//  Own-fleet board for the battleship game: 10x10 grid of 2-bit cell states.
//  Sits directly downstream of the game-control FSM and consumes its grid-cell code (row[7:4], col[3:0]) and pick_ship.
//  Validates and stores ship placements, counts them, and answers opponent shots with hit/miss.
//  Feeds ship_count back to the game-control FSM and a read port to the board renderer.
// PARAMETERS
//  SHIPS      10  number of single-cell ships to place; place_done when reached
//  GRID       10  rows/cols; valid coordinate 0..GRID-1
// PORTS
//  clk             in   1  system clock
//  rst             in   1  reset, synchronous, active-high
//  board_clear     in   1  pulse: wipe board, count=0, abort any operation
//  place_en        in   1  placement phase active (pick_ship)
//  cell_valid      in   1  1-cycle pulse: placement request
//  cell_in         in   8  placement cell, row[7:4] col[3:0]
//  shot_valid      in   1  1-cycle pulse: opponent shot
//  shot_cell       in   8  shot cell, row[7:4] col[3:0]
//  busy            out  1  operation in progress; new requests dropped
//  place_ack       out  1  1-cycle pulse: ship written
//  place_nack      out  1  1-cycle pulse: placement rejected
//  ship_count      out  4  ships placed, 0..SHIPS
//  place_done      out  1  ship_count==SHIPS
//  shot_resp       out  1  1-cycle pulse: shot answered
//  shot_hit        out  1  valid with shot_resp: cell held a ship
//  shot_repeat     out  1  valid with shot_resp: already shot or out of range
//  ships_left      out  4  unsunk ships; 0 with place_done => fleet destroyed
//  rd_cell         in   8  render read address
//  rd_state        out  2  cell state at rd_cell, 1-cycle latency, EMPTY if out of range
// BEHAVIOUR
//  - Reset / board_clear: all cells EMPTY; FSM to IDLE.
//    All outputs 0, including ship_count, ships_left and rd_state.
//    board_clear acts in any state and issues no ack/resp.
//  - Cell states: EMPTY=0, SHIP=1, HIT=2, MISS=3.
//  - FSM: IDLE -> P_CHECK -> P_DECIDE -> IDLE for placement; IDLE -> S_LOOK -> S_RESP -> IDLE for shots.
//  - busy=1 in every state except IDLE.
//  - Acceptance in IDLE only:
//    - shot_valid has priority over cell_valid on the same cycle; the loser is dropped.
//    - cell_valid is ignored unless place_en=1 and ship_count<SHIPS.
//  - Placement is accepted at cycle N. In P_CHECK, the target cell is read (registered).
//    At N+2, exactly one of place_ack/place_nack fires:
//    - nack if row>=GRID or col>=GRID (covers underflowed mouse maths, e.g. 0xFF), or if the cell is not EMPTY.
//    - Otherwise the cell is written SHIP, and ship_count and ships_left increment in the same cycle.
//  - Shot is accepted at cycle N; shot_resp fires at N+2:
//    - Out of range, or cell HIT/MISS: shot_hit=0, shot_repeat=1, no write.
//    - SHIP: write HIT, shot_hit=1, ships_left-1 (saturates at 0).
//    - EMPTY: write MISS, shot_hit=0.
//  - Render read port is independent of the FSM.
//    If the write and the read address the same cell in the same cycle, rd_state returns the old value.
//  - Widths: coordinates are 4-bit unsigned, compared against GRID; cell index = row*GRID+col (7 bits).
// CONFIGURATION
//  ADJACENCY_CHECK_EN defined:
//  - P_CHECK scans the 3x3 neighbourhood, one cell per cycle, row-major from (r-1,c-1): 9 reads.
//  - Off-grid neighbours count as EMPTY but still take a cycle.
//  - Any non-EMPTY neighbour or centre => nack.
//  - Decision at fixed N+10.
//  Not defined: centre cell only, decision at N+2, touching ships allowed.
// STRUCTURE
//  game_pkg: cell_state_t enum (EMPTY/SHIP/HIT/MISS), GRID_MAX, fsm state enum, coord helper function in_grid().
//  Sub-module board_mem:
//  - 100x2-bit storage with one synchronous write port, one FSM read port and one render read port (both 1-cycle).
//  - Supports whole-array synchronous clear.
// TESTING
//  T1:
//  - Stimulus: place_en=1, cell_valid with cell_in=8'h23.
//  - Response: place_ack at N+2, ship_count=1, rd_cell=8'h23 gives rd_state=1.
//  T2:
//  - Stimulus: 10 valid placements at distinct cells, then an 11th at 8'h99.
//  - Response: place_done=1, ship_count=10; the 11th produces no ack/nack and the cell stays EMPTY.
//  T3:
//  - Stimulus: place at 8'h23, then 8'h23 again, then 8'hA0, then 8'hFF.
//  - Response: 1 ack, then 3 nacks; ship_count=1.
//  - With ADJACENCY_CHECK_EN, 8'h34 also nacks at N+10.
//  T4:
//  - Stimulus: ship at 8'h55; shots at 55, 55, 56.
//  - Response: hit=1, ships_left 1->0; then repeat=1; then hit=0 and cell 56 becomes MISS.
//  T5:
//  - Stimulus: shot_valid and cell_valid in the same cycle; then cell_valid while busy.
//  - Response: only the shot is answered; the second request is dropped, with no ack/nack.
//  T6:
//  - Stimulus: board_clear, then rst, each asserted mid-P_CHECK.
//  - Response: no ack/nack, all cells EMPTY, counts 0, FSM accepts a request the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and coordinate helpers for the battleship own-fleet board.
package game_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHIP  = 2'd1,
      HIT   = 2'd2,
      MISS  = 2'd3
   } cell_state_t;

   localparam int GRID_MAX = 10;

   typedef enum logic [2:0] {
      IDLE,
      P_CHECK,
      P_DECIDE,
      S_LOOK,
      S_RESP
   } fsm_state_t;

   function automatic logic in_grid(input logic [3:0] r, input logic [3:0] c, input int grid);
      return (int'(r) < grid) && (int'(c) < grid);
   endfunction

   // Only meaningful when in_grid() holds; off-grid results are truncated junk.
   function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c, input int grid);
      return 7'(int'(r) * grid + int'(c));
   endfunction

endpackage

// File: rtl/board_mem.sv
// Cell-state storage: one sync write port, two 1-cycle read ports, whole-array sync clear.
module board_mem
   import game_pkg::*;
#(
   parameter int GRID = GRID_MAX
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        we,
   input  logic [6:0]  waddr,
   input  cell_state_t wdata,
   input  logic        fsm_rvld,
   input  logic [6:0]  fsm_raddr,
   output cell_state_t fsm_rdata,
   input  logic        ren_rvld,
   input  logic [6:0]  ren_raddr,
   output cell_state_t ren_rdata
);

   localparam int CELLS = GRID * GRID;

   cell_state_t mem [CELLS];

   // Reads sample the array before this edge's write, so a colliding read sees the old value.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < CELLS; i++) mem[i] <= EMPTY;
         fsm_rdata <= EMPTY;
         ren_rdata <= EMPTY;
      end else begin
         if (we) mem[waddr] <= wdata;
         fsm_rdata <= fsm_rvld ? mem[fsm_raddr] : EMPTY;
         ren_rdata <= ren_rvld ? mem[ren_raddr] : EMPTY;
      end
   end

endmodule

// File: rtl/ship_board.sv
// Own-fleet board: validates placements, answers shots, exposes a render read port.
// Define ADJACENCY_CHECK_EN to reject placements touching another ship (3x3 scan).
module ship_board
   import game_pkg::*;
#(
   parameter int SHIPS = 10,
   parameter int GRID  = GRID_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       board_clear,
   input  logic       place_en,
   input  logic       cell_valid,
   input  logic [7:0] cell_in,
   input  logic       shot_valid,
   input  logic [7:0] shot_cell,
   output logic       busy,
   output logic       place_ack,
   output logic       place_nack,
   output logic [3:0] ship_count,
   output logic       place_done,
   output logic       shot_resp,
   output logic       shot_hit,
   output logic       shot_repeat,
   output logic [3:0] ships_left,
   input  logic [7:0] rd_cell,
   output logic [1:0] rd_state
);

`ifdef ADJACENCY_CHECK_EN
   localparam bit ADJ = 1'b1;
`else
   localparam bit ADJ = 1'b0;
`endif
   localparam logic [3:0] SCAN_LAST = ADJ ? 4'd8 : 4'd0;

   // Neighbour k (row-major from the top-left) as offsets biased by +1.
   function automatic logic [3:0] off_r(input logic [3:0] k, input bit adj);
      return adj ? k / 4'd3 : 4'd1;
   endfunction
   function automatic logic [3:0] off_c(input logic [3:0] k, input bit adj);
      return adj ? k % 4'd3 : 4'd1;
   endfunction

   fsm_state_t  state, state_nx;
   logic [3:0]  req_row, req_col, scan_cnt;
   logic        bad_acc, cur_bad, centre_ok, scan_last;
   logic        clr, place_acc;
   logic [3:0]  base_row, base_col, scan_k, fr, fc;
   logic        mem_we;
   cell_state_t mem_wdata, fsm_rdata, ren_rdata;
   logic        ack_d, nack_d, resp_d, hit_d, rep_d;

   assign clr       = rst | board_clear;
   assign busy      = (state != IDLE);
   assign place_acc = (state == IDLE) && !shot_valid && cell_valid && place_en &&
                      (int'(ship_count) < SHIPS);
   assign place_done = (int'(ship_count) == SHIPS);
   assign centre_ok = in_grid(req_row, req_col, GRID);
   assign scan_last = (scan_cnt == SCAN_LAST);
   assign cur_bad   = bad_acc | (fsm_rdata != EMPTY);

   // The first read is issued straight from the request inputs while still in IDLE,
   // so data for neighbour k arrives in P_CHECK at scan_cnt == k.
   always_comb begin
      base_row = req_row;
      base_col = req_col;
      scan_k   = scan_cnt + 4'd1;
      if (state == IDLE) begin
         scan_k   = 4'd0;
         base_row = shot_valid ? shot_cell[7:4] : cell_in[7:4];
         base_col = shot_valid ? shot_cell[3:0] : cell_in[3:0];
      end
      fr = base_row;
      fc = base_col;
      if (!(state == IDLE && shot_valid)) begin
         fr = base_row + off_r(scan_k, ADJ) - 4'd1;
         fc = base_col + off_c(scan_k, ADJ) - 4'd1;
      end
   end

   board_mem #(.GRID(GRID)) u_mem (
      .clk       (clk),
      .clr       (clr),
      .we        (mem_we),
      .waddr     (cell_idx(req_row, req_col, GRID)),
      .wdata     (mem_wdata),
      .fsm_rvld  (in_grid(fr, fc, GRID)),
      .fsm_raddr (cell_idx(fr, fc, GRID)),
      .fsm_rdata (fsm_rdata),
      .ren_rvld  (in_grid(rd_cell[7:4], rd_cell[3:0], GRID)),
      .ren_raddr (cell_idx(rd_cell[7:4], rd_cell[3:0], GRID)),
      .ren_rdata (ren_rdata)
   );

   assign rd_state = ren_rdata;

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (shot_valid) state_nx = S_LOOK;
                   else if (place_acc) state_nx = P_CHECK;
         P_CHECK:  if (scan_last) state_nx = P_DECIDE;
         P_DECIDE: state_nx = IDLE;
         S_LOOK:   state_nx = S_RESP;
         S_RESP:   state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Decisions are made one state early so responses and counts register together.
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = EMPTY;
      ack_d     = 1'b0;
      nack_d    = 1'b0;
      resp_d    = 1'b0;
      hit_d     = 1'b0;
      rep_d     = 1'b0;
      case (state)
         P_CHECK: if (scan_last) begin
            if (centre_ok && !cur_bad) begin
               mem_we    = 1'b1;
               mem_wdata = SHIP;
               ack_d     = 1'b1;
            end else begin
               nack_d = 1'b1;
            end
         end
         S_LOOK: begin
            resp_d = 1'b1;
            if (!centre_ok || fsm_rdata == HIT || fsm_rdata == MISS) begin
               rep_d = 1'b1;
            end else begin
               mem_we = 1'b1;
               if (fsm_rdata == SHIP) begin
                  mem_wdata = HIT;
                  hit_d     = 1'b1;
               end else begin
                  mem_wdata = MISS;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         req_row     <= '0;
         req_col     <= '0;
         scan_cnt    <= '0;
         bad_acc     <= 1'b0;
         place_ack   <= 1'b0;
         place_nack  <= 1'b0;
         shot_resp   <= 1'b0;
         shot_hit    <= 1'b0;
         shot_repeat <= 1'b0;
         ship_count  <= '0;
         ships_left  <= '0;
      end else begin
         if (state == IDLE && (shot_valid || place_acc)) begin
            req_row <= shot_valid ? shot_cell[7:4] : cell_in[7:4];
            req_col <= shot_valid ? shot_cell[3:0] : cell_in[3:0];
         end
         scan_cnt    <= (state == P_CHECK) ? scan_cnt + 4'd1 : 4'd0;
         bad_acc     <= (state == P_CHECK) && cur_bad;
         place_ack   <= ack_d;
         place_nack  <= nack_d;
         shot_resp   <= resp_d;
         shot_hit    <= hit_d;
         shot_repeat <= rep_d;
         if (ack_d) begin
            ship_count <= ship_count + 4'd1;
            ships_left <= ships_left + 4'd1;
         end else if (hit_d && ships_left != 4'd0) begin
            ships_left <= ships_left - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ship_board.sv
// Randomized scoreboard bench for ship_board against a grid-array reference model.
module tb_ship_board;
   import game_pkg::*;

`ifdef ADJACENCY_CHECK_EN
   localparam bit ADJ = 1'b1;
   localparam int LAT = 10;
`else
   localparam bit ADJ = 1'b0;
   localparam int LAT = 2;
`endif
   localparam int SHIPS = 10;
   localparam int GRID  = 10;

   logic       clk = 1'b0, rst = 1'b1, board_clear = 1'b0, place_en = 1'b0;
   logic       cell_valid = 1'b0, shot_valid = 1'b0;
   logic [7:0] cell_in = '0, shot_cell = '0, rd_cell = '0;
   logic       busy, place_ack, place_nack, place_done, shot_resp, shot_hit, shot_repeat;
   logic [3:0] ship_count, ships_left;
   logic [1:0] rd_state;

   ship_board #(.SHIPS(SHIPS), .GRID(GRID)) dut (
      .clk(clk), .rst(rst), .board_clear(board_clear), .place_en(place_en),
      .cell_valid(cell_valid), .cell_in(cell_in), .shot_valid(shot_valid),
      .shot_cell(shot_cell), .busy(busy), .place_ack(place_ack),
      .place_nack(place_nack), .ship_count(ship_count), .place_done(place_done),
      .shot_resp(shot_resp), .shot_hit(shot_hit), .shot_repeat(shot_repeat),
      .ships_left(ships_left), .rd_cell(rd_cell), .rd_state(rd_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_shot;
      bit ack;
      bit hit;
      bit rep;
      int cyc;
      int cnt;
      int left;
   } exp_t;

   exp_t q[$];
   int   ntests = 0, nfail = 0;
   int   board[GRID*GRID];
   int   m_cnt = 0, m_left = 0;

   task automatic check(input string name, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic m_clear();
      for (int i = 0; i < GRID*GRID; i++) board[i] = 0;
      m_cnt  = 0;
      m_left = 0;
   endtask

   task automatic m_place(input logic [7:0] c, output exp_t e);
      int r, k;
      bit ok;
      r  = c[7:4];
      k  = c[3:0];
      ok = (r < GRID) && (k < GRID);
      if (ok) begin
         if (ADJ) begin
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (r+dr >= 0 && r+dr < GRID && k+dc >= 0 && k+dc < GRID &&
                      board[(r+dr)*GRID + k+dc] != 0) ok = 0;
         end else if (board[r*GRID + k] != 0) begin
            ok = 0;
         end
      end
      if (ok) begin
         board[r*GRID + k] = 1;
         m_cnt++;
         m_left++;
      end
      e = '{is_shot:1'b0, ack:ok, hit:1'b0, rep:1'b0, cyc:cyc+LAT, cnt:m_cnt, left:m_left};
   endtask

   task automatic m_shot(input logic [7:0] c, output exp_t e);
      int r, k;
      bit h, rp;
      r  = c[7:4];
      k  = c[3:0];
      h  = 0;
      rp = 0;
      if (r >= GRID || k >= GRID || board[r*GRID + k] >= 2) begin
         rp = 1;
      end else if (board[r*GRID + k] == 1) begin
         h = 1;
         board[r*GRID + k] = 2;
         if (m_left > 0) m_left--;
      end else begin
         board[r*GRID + k] = 3;
      end
      e = '{is_shot:1'b1, ack:1'b0, hit:h, rep:rp, cyc:cyc+2, cnt:m_cnt, left:m_left};
   endtask

   function automatic int m_read(input logic [7:0] c);
      int r, k;
      r = c[7:4];
      k = c[3:0];
      return (r < GRID && k < GRID) ? board[r*GRID + k] : 0;
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (place_ack || place_nack || shot_resp) begin
            if (q.size() == 0) begin
               check("unexpected_resp", int'({place_ack, place_nack, shot_resp}), 0);
            end else begin
               e = q.pop_front();
               check("resp_cycle", cyc, e.cyc);
               if (e.is_shot)
                  check("shot_bits", int'({place_ack, place_nack, shot_resp, shot_hit, shot_repeat}),
                        int'({3'b001, e.hit, e.rep}));
               else
                  check("place_bits", int'({place_ack, place_nack, shot_resp}),
                        e.ack ? 4 : 2);
               check("ship_count", int'(ship_count), e.cnt);
               check("ships_left", int'(ships_left), e.left);
               check("place_done", int'(place_done), int'(e.cnt == SHIPS));
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_idle();
      int n = 0;
      while ((busy || q.size() != 0) && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         check("idle_timeout", n, 0);
         q.delete();
      end
   endtask

   task automatic do_place(input logic [7:0] c, input bit pe);
      exp_t e;
      wait_idle();
      place_en   = pe;
      cell_in    = c;
      cell_valid = 1'b1;
      if (pe && m_cnt < SHIPS) begin
         m_place(c, e);
         q.push_back(e);
      end
      @(negedge clk);
      cell_valid = 1'b0;
   endtask

   task automatic do_shot(input logic [7:0] c);
      exp_t e;
      wait_idle();
      shot_cell  = c;
      shot_valid = 1'b1;
      m_shot(c, e);
      q.push_back(e);
      @(negedge clk);
      shot_valid = 1'b0;
   endtask

   task automatic chk_rd(input logic [7:0] c);
      wait_idle();
      rd_cell = c;
      @(negedge clk);
      check("rd_state", int'(rd_state), m_read(c));
   endtask

   task automatic do_clear();
      wait_idle();
      board_clear = 1'b1;
      @(negedge clk);
      board_clear = 1'b0;
      m_clear();
   endtask

   // Start a placement, kill it one cycle later with clear or reset, then re-issue at once.
   task automatic abort_test(input bit use_rst);
      exp_t e;
      do_place(8'h77, 1'b1);
      wait_idle();
      place_en   = 1'b1;
      cell_in    = 8'h11;
      cell_valid = 1'b1;
      @(negedge clk);
      cell_valid = 1'b0;
      if (use_rst) rst = 1'b1; else board_clear = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      board_clear = 1'b0;
      m_clear();
      check("abort_busy", int'(busy), 0);
      check("abort_count", int'({ship_count, ships_left}), 0);
      cell_in    = 8'h44;
      cell_valid = 1'b1;
      m_place(8'h44, e);
      q.push_back(e);
      @(negedge clk);
      cell_valid = 1'b0;
      check("accept_after_abort", int'(busy), 1);
      chk_rd(8'h77);
      chk_rd(8'h11);
   endtask

   function automatic logic [7:0] rnd_cell();
      if ($urandom_range(0, 4) == 0) return 8'($urandom);
      return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      exp_t e;
      m_clear();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_outs", int'({busy, place_ack, place_nack, shot_resp, shot_hit, shot_repeat,
                               place_done, ship_count, ships_left, rd_state}), 0);

      // T1: first placement, with a same-cycle render read of the written cell
      wait_idle();
      place_en   = 1'b1;
      cell_in    = 8'h23;
      cell_valid = 1'b1;
      m_place(8'h23, e);
      q.push_back(e);
      @(negedge clk);
      cell_valid = 1'b0;
      repeat (LAT - 2) @(negedge clk);
      rd_cell = 8'h23;
      @(negedge clk);
      check("rd_same_cycle_old", int'(rd_state), 0);
      chk_rd(8'h23);

      // T2: fill the fleet, then an extra request is ignored
      do_clear();
      for (int i = 0; i < 10; i++)
         do_place({4'(2 * (i / 2)), 4'(5 * (i % 2))}, 1'b1);
      do_place(8'h99, 1'b1);
      chk_rd(8'h99);

      // T3: duplicate, out-of-range and (adjacent) rejections
      do_clear();
      do_place(8'h23, 1'b1);
      do_place(8'h23, 1'b1);
      do_place(8'hA0, 1'b1);
      do_place(8'hFF, 1'b1);
      do_place(8'h34, 1'b1);

      // T4: hit, repeat, miss
      do_clear();
      do_place(8'h55, 1'b1);
      do_shot(8'h55);
      do_shot(8'h55);
      do_shot(8'h56);
      chk_rd(8'h56);
      chk_rd(8'h55);

      // T5: shot beats placement; placement while busy dropped
      do_clear();
      wait_idle();
      shot_cell  = 8'h11;
      shot_valid = 1'b1;
      place_en   = 1'b1;
      cell_in    = 8'h22;
      cell_valid = 1'b1;
      m_shot(8'h11, e);
      q.push_back(e);
      @(negedge clk);
      shot_valid = 1'b0;
      cell_in    = 8'h33;
      check("busy_after_accept", int'(busy), 1);
      @(negedge clk);
      cell_valid = 1'b0;
      chk_rd(8'h22);
      chk_rd(8'h33);

      // T6: abort by board_clear and by reset
      abort_test(1'b0);
      abort_test(1'b1);

      // Randomized mix
      do_clear();
      for (int i = 0; i < 400; i++) begin
         int op;
         logic [7:0] c;
         op = $urandom_range(0, 19);
         c  = rnd_cell();
         if (op < 8)       do_place(c, $urandom_range(0, 9) != 0);
         else if (op < 15) do_shot(c);
         else if (op < 19) chk_rd(c);
         else              do_clear();
      end

      wait_idle();
      repeat (2) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
